// File: rtl/bus_arbiter6809.sv
// Memory-port arbiter between the 6809 core and one DMA master: halts the core,
// grants a bounded DMA burst, then guarantees the CPU a minimum ownership window.
module bus_arbiter6809 #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CPU_SLOTS = 4
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw_n,
    output logic [7:0]  cpu_rdata,
    input  logic        cpu_ba,
    output logic        halt_b,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_rw_n,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw_n,
    input  logic [7:0]  mem_rdata,
    output logic        arb_err,
    output logic [15:0] dma_cycles
);

    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned CW = (CPU_SLOTS > 1) ? $clog2(CPU_SLOTS) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(CPU_SLOTS - 1);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_HALT_WAIT,
        ST_DMA,
        ST_COOL
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [BW-1:0]   r_burst_cnt;
    logic [CW-1:0]   r_cool_cnt;
    logic            r_arb_err;
    logic [15:0]     r_dma_cycles;
    logic            w_halt_b;
    logic            w_gnt;

    // Outputs depend on state only; the data inputs never reach halt_b or dma_gnt.
    always_comb begin
        w_next   = r_state;
        w_halt_b = 1'b1;
        w_gnt    = 1'b0;
        case (r_state)
            ST_CPU: begin
                if (dma_req) begin
                    w_next = ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                w_halt_b = 1'b0;
                if (!dma_req) begin
                    w_next = ST_CPU;
                end else if (cpu_ba) begin
                    w_next = ST_DMA;
                end
            end
            ST_DMA: begin
                w_halt_b = 1'b0;
                w_gnt    = 1'b1;
                if (!cpu_ba || !dma_req || (r_burst_cnt == BURST_LAST)) begin
                    w_next = ST_COOL;
                end
            end
            ST_COOL: begin
                if (r_cool_cnt == COOL_LAST) begin
                    w_next = ST_CPU;
                end
            end
            default: begin
                w_next = ST_CPU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_state      <= ST_CPU;
            r_burst_cnt  <= '0;
            r_cool_cnt   <= '0;
            r_arb_err    <= 1'b0;
            r_dma_cycles <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_HALT_WAIT: begin
                    r_burst_cnt <= '0;
                end
                ST_DMA: begin
                    r_burst_cnt <= r_burst_cnt + BW'(1);
                    if (r_dma_cycles != '1) begin
                        r_dma_cycles <= r_dma_cycles + 16'd1;
                    end
                    // Core left the halted state while we still drive the bus.
                    if (!cpu_ba) begin
                        r_arb_err <= 1'b1;
                    end
                    if (w_next == ST_COOL) begin
                        r_cool_cnt <= '0;
                    end
                end
                ST_COOL: begin
                    r_cool_cnt <= r_cool_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // A DMA master that withdraws on the final granted cycle must not leave a write strobe behind.
    always_comb begin
        if (w_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_rw_n  = dma_req ? dma_rw_n : 1'b1;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_rw_n  = cpu_rw_n;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign halt_b     = w_halt_b;
    assign dma_gnt    = w_gnt;
    assign arb_err    = r_arb_err;
    assign dma_cycles = r_dma_cycles;

endmodule

// File: tb/tb_bus_arbiter6809.sv
// Directed self-checking bench for bus_arbiter6809; a second instance with a very
// long burst limit exercises the saturating DMA cycle counter.
module tb_bus_arbiter6809;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_rw_n = 1'b1;
    logic        cpu_ba = 1'b0;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_rw_n = 1'b1;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  cpu_rdata;
    logic        halt_b;
    logic        dma_gnt;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rw_n;
    logic        arb_err;
    logic [15:0] dma_cycles;

    logic        s_req = 1'b0;
    logic        s_ba = 1'b0;
    logic [7:0]  s_cpu_rdata;
    logic        s_halt_b;
    logic        s_gnt;
    logic [7:0]  s_dma_rdata;
    logic [15:0] s_mem_addr;
    logic [7:0]  s_mem_wdata;
    logic        s_mem_rw_n;
    logic        s_arb_err;
    logic [15:0] s_cycles;

    int n_cmp = 0;
    int n_err = 0;
    logic [24:0] exp5 [6];

    always #5 clk = ~clk;

    bus_arbiter6809 #(.MAX_BURST(16), .CPU_SLOTS(4)) u_dut (
        .clk(clk), .reset_b(reset_b),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw_n(cpu_rw_n), .cpu_rdata(cpu_rdata),
        .cpu_ba(cpu_ba), .halt_b(halt_b),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rw_n(dma_rw_n), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw_n(mem_rw_n), .mem_rdata(mem_rdata),
        .arb_err(arb_err), .dma_cycles(dma_cycles)
    );

    bus_arbiter6809 #(.MAX_BURST(65536), .CPU_SLOTS(4)) u_sat (
        .clk(clk), .reset_b(reset_b),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw_n(cpu_rw_n), .cpu_rdata(s_cpu_rdata),
        .cpu_ba(s_ba), .halt_b(s_halt_b),
        .dma_req(s_req), .dma_gnt(s_gnt), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rw_n(dma_rw_n), .dma_rdata(s_dma_rdata),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rw_n(s_mem_rw_n), .mem_rdata(mem_rdata),
        .arb_err(s_arb_err), .dma_cycles(s_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        dma_req = 1'b0;
        cpu_ba  = 1'b0;
        next();
        reset_b = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        exp5 = '{{16'h4000, 8'h5A, 1'b0}, {16'h4000, 8'h5A, 1'b0},
                 {16'h1234, 8'hA5, 1'b0}, {16'h1234, 8'hA5, 1'b0},
                 {16'h1234, 8'hA5, 1'b1}, {16'h4000, 8'h5A, 1'b0}};

        // reset held with a pending request
        dma_req  = 1'b1;
        cpu_ba   = 1'b1;
        cpu_addr = 16'h1111;
        next();
        next();
        mid();
        chk("rst_halt", halt_b, 1);
        chk("rst_gnt", dma_gnt, 0);
        chk("rst_mem_addr", mem_addr, 16'h1111);
        chk("rst_cycles", dma_cycles, 0);
        chk("rst_err", arb_err, 0);
        dma_req = 1'b0;
        cpu_ba  = 1'b0;
        reset_b = 1'b1;
        next();

        // single DMA transaction
        cpu_addr = 16'h3333;
        dma_addr = 16'h2222;
        dma_req  = 1'b1;
        mid();
        chk("t2_T0", {halt_b, dma_gnt}, 2'b10);
        next();
        mid();
        chk("t2_T1", {halt_b, dma_gnt}, 2'b00);
        next();
        cpu_ba = 1'b1;
        mid();
        chk("t2_T2", {halt_b, dma_gnt}, 2'b00);
        chk("t2_T2_addr", mem_addr, 16'h3333);
        next();
        mid();
        chk("t2_T3", {halt_b, dma_gnt}, 2'b01);
        chk("t2_T3_addr", mem_addr, 16'h2222);
        next();
        mid();
        chk("t2_T4", {halt_b, dma_gnt}, 2'b01);
        next();
        dma_req  = 1'b0;
        dma_rw_n = 1'b0;
        mid();
        chk("t2_T5", {halt_b, dma_gnt}, 2'b01);
        chk("t2_T5_rw", mem_rw_n, 1);
        next();
        dma_req  = 1'b1;
        dma_rw_n = 1'b1;
        mid();
        chk("t2_T6", {halt_b, dma_gnt}, 2'b10);
        chk("t2_cycles", dma_cycles, 3);
        for (int i = 0; i < 4; i++) begin
            next();
            mid();
            chk("t2_cpu_window", {halt_b, dma_gnt}, 2'b10);
        end
        next();
        mid();
        chk("t2_rehalt", {halt_b, dma_gnt}, 2'b00);
        dma_req = 1'b0;
        cpu_ba  = 1'b0;
        next();
        mid();
        chk("t2_abort_back", {halt_b, dma_gnt}, 2'b10);
        next();

        // burst cap: 22-cycle period CPU, HALT_WAIT, 16 x DMA, 4 x COOL
        do_reset();
        dma_req = 1'b1;
        cpu_ba  = 1'b1;
        for (int c = 0; c < 66; c++) begin
            int p;
            p = c % 22;
            mid();
            chk("t3_seq", {halt_b, dma_gnt}, {!(p >= 1 && p <= 17), (p >= 2 && p <= 17)});
            next();
        end
        mid();
        chk("t3_cycles", dma_cycles, 48);
        chk("t3_end", {halt_b, dma_gnt}, 2'b10);
        dma_req = 1'b0;
        next();

        // abort: request one cycle, core never releases the bus
        dma_req = 1'b1;
        cpu_ba  = 1'b0;
        mid();
        chk("t4_T0", {halt_b, dma_gnt}, 2'b10);
        next();
        dma_req = 1'b0;
        mid();
        chk("t4_T1", {halt_b, dma_gnt}, 2'b00);
        next();
        mid();
        chk("t4_T2", {halt_b, dma_gnt}, 2'b10);
        next();
        mid();
        chk("t4_T3", {halt_b, dma_gnt}, 2'b10);
        chk("t4_cycles", dma_cycles, 48);
        next();

        // write isolation
        cpu_addr  = 16'h4000;
        cpu_wdata = 8'h5A;
        cpu_rw_n  = 1'b0;
        dma_addr  = 16'h1234;
        dma_wdata = 8'hA5;
        dma_rw_n  = 1'b0;
        mem_rdata = 8'h3C;
        dma_req   = 1'b1;
        cpu_ba    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) dma_req = 1'b0;
            mid();
            chk("t5_bus", {mem_addr, mem_wdata, mem_rw_n}, exp5[i]);
            if (i == 0) chk("t5_rdata", {cpu_rdata, dma_rdata}, 16'h3C3C);
            next();
        end
        cpu_rw_n = 1'b1;
        dma_rw_n = 1'b1;
        next();
        next();
        next();

        // cpu_ba drops during a grant
        dma_req = 1'b1;
        cpu_ba  = 1'b1;
        next();
        next();
        mid();
        chk("t6_T2_gnt", dma_gnt, 1);
        next();
        cpu_ba = 1'b0;
        mid();
        chk("t6_T3_gnt", dma_gnt, 1);
        chk("t6_T3_err", arb_err, 0);
        next();
        mid();
        chk("t6_T4_gnt", dma_gnt, 0);
        chk("t6_T4_err", arb_err, 1);
        chk("t6_cycles", dma_cycles, 53);
        dma_req = 1'b0;
        for (int i = 0; i < 4; i++) next();
        mid();
        chk("t6_sticky", {arb_err, halt_b, dma_gnt}, 3'b110);
        next();
        do_reset();
        mid();
        chk("t6_err_clr", arb_err, 0);
        chk("t6_cycles_clr", dma_cycles, 0);

        // saturation: 65540 granted cycles on the long-burst instance
        s_req = 1'b1;
        s_ba  = 1'b1;
        next();
        k = 0;
        for (int c = 0; c < 70000 && k < 65540; c++) begin
            mid();
            if (s_gnt) begin
                k++;
                if (k == 65535) chk("sat_pre", s_cycles, 16'hFFFE);
            end
            if (k < 65540) next();
        end
        chk("sat_grants", k, 65540);
        s_req = 1'b0;
        next();
        mid();
        chk("sat_cycles", s_cycles, 16'hFFFF);
        chk("sat_cool", {s_halt_b, s_gnt}, 2'b10);
        for (int i = 0; i < 4; i++) next();
        mid();
        chk("sat_idle", {s_halt_b, s_gnt, s_arb_err}, 3'b100);
        chk("sat_mux", {s_mem_addr, s_mem_wdata, s_mem_rw_n, s_cpu_rdata, s_dma_rdata},
            {cpu_addr, cpu_wdata, cpu_rw_n, mem_rdata, mem_rdata});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
